// File: rtl/stage_three.sv
`default_nettype none
// ============================================================================
//  Module   : stage_three
//  Brief    : Memory-access / write-back stage with req/ack data-memory port,
//             write-back bubbles while an access is outstanding.
//  Options  : MEM_TIMEOUT_EN - abort a WAIT after TIMEOUT cycles, sticky mem_err
//  Revision : 1.0
// ============================================================================

package types_pkg;
    typedef struct packed {
        logic mem2r;
        logic memwr;
    } memc_t;
endpackage

module stage_three #(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_sys,
    input  types_pkg::memc_t  in_memc,
    input  logic              in_reg_wr,
    input  logic              in_R0_en,
    input  logic [15:0]       in_instr,
    input  logic [31:0]       in_alu,
    input  logic [15:0]       in_R1_data,
    output logic              dm_req,
    output logic              dm_we,
    output logic [15:0]       dm_addr,
    output logic [15:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [15:0]       dm_rdata,
    output logic [15:0]       s3_instruction,
    output logic [31:0]       s3_data,
    output logic              s3_reg_wr,
    output logic              s3_mem2r,
    output logic              s3_R0_en,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_wait = 1'b1;

    if (TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_timeout
        $error("stage_three: TIMEOUT must lie in 1..31");
    end

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic        w_memop;
    logic        w_issue;
    logic        w_in_wait;
    logic        w_abort;
    logic        w_complete;
    logic        w_store;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_instr;
    logic [31:0] r_alu;
    logic        r_we;

    assign w_memop    = in_memc.mem2r | in_memc.memwr;
    // Gating with rst keeps dm_req/mem_busy low for the whole reset pulse.
    assign w_issue    = (r_state == c_st_idle) & w_memop & ~halt_sys & ~rst;
    assign w_in_wait  = (r_state == c_st_wait);
    assign w_complete = (w_issue | w_in_wait) & dm_ack;
    assign w_store    = w_issue ? in_memc.memwr : r_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_issue && !dm_ack)    w_state_next = c_st_wait;
            c_st_wait: if (dm_ack || w_abort)     w_state_next = c_st_idle;
            default:                              w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        dm_req   = w_issue | w_in_wait;
        dm_we    = 1'b0;
        dm_addr  = r_addr;
        dm_wdata = r_wdata;
        mem_busy = 1'b0;
        if (w_issue) begin
            dm_we    = in_memc.memwr;
            dm_addr  = in_alu[15:0];
            dm_wdata = in_R1_data;
            mem_busy = ~dm_ack;
        end else if (w_in_wait) begin
            dm_we    = r_we;
            mem_busy = ~dm_ack & ~w_abort;
        end
    end

    // Access context captured only when the access actually has to wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_instr <= '0;
            r_alu   <= '0;
            r_we    <= 1'b0;
        end else if (w_issue && !dm_ack) begin
            r_addr  <= in_alu[15:0];
            r_wdata <= in_R1_data;
            r_instr <= in_instr;
            r_alu   <= in_alu;
            r_we    <= in_memc.memwr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_instruction <= '0;
            s3_data        <= '0;
            s3_reg_wr      <= 1'b0;
            s3_mem2r       <= 1'b0;
            s3_R0_en       <= 1'b0;
        end else if (w_complete) begin
            s3_instruction <= w_issue ? in_instr : r_instr;
            s3_data        <= w_store ? (w_issue ? in_alu : r_alu) : {16'd0, dm_rdata};
            s3_mem2r       <= ~w_store;
            s3_reg_wr      <= 1'b0;
            s3_R0_en       <= 1'b0;
        end else if (w_issue || w_in_wait) begin
            // Stalled or aborted access: write-back bubble, data left as is.
            s3_instruction <= '0;
            s3_reg_wr      <= 1'b0;
            s3_mem2r       <= 1'b0;
            s3_R0_en       <= 1'b0;
        end else if (!halt_sys) begin
            s3_instruction <= in_instr;
            s3_data        <= in_alu;
            s3_reg_wr      <= in_reg_wr;
            s3_mem2r       <= 1'b0;
            s3_R0_en       <= in_R0_en;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [5:0] c_timeout = 6'(TIMEOUT);

    logic [4:0] r_wait_cnt;
    logic       r_mem_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (!w_in_wait) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != 5'h1f) begin
            r_wait_cnt <= r_wait_cnt + 5'd1;
        end
    end

    // Abort in the WAIT cycle whose closing edge brings the count to TIMEOUT.
    assign w_abort = w_in_wait & (({1'b0, r_wait_cnt} + 6'd1) == c_timeout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_err <= 1'b0;
        end else if (w_abort && !dm_ack) begin
            r_mem_err <= 1'b1;
        end
    end

    assign mem_err = r_mem_err;
`else
    assign w_abort = 1'b0;
    assign mem_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stage_three.sv
`default_nettype none
// Self-checking bench for stage_three: directed vector table, randomized
// transactions against a transaction-level model, reset and timeout sequences.
module tb_stage_three;

`ifdef MEM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 15;
`endif

    localparam types_pkg::memc_t M_NONE = types_pkg::memc_t'(2'b00);
    localparam types_pkg::memc_t M_LD   = types_pkg::memc_t'(2'b10);
    localparam types_pkg::memc_t M_ST   = types_pkg::memc_t'(2'b01);

    logic              clk = 1'b0;
    logic              rst;
    logic              halt_sys;
    types_pkg::memc_t  in_memc;
    logic              in_reg_wr;
    logic              in_R0_en;
    logic [15:0]       in_instr;
    logic [31:0]       in_alu;
    logic [15:0]       in_R1_data;
    logic              dm_req;
    logic              dm_we;
    logic [15:0]       dm_addr;
    logic [15:0]       dm_wdata;
    logic              dm_ack;
    logic [15:0]       dm_rdata;
    logic [15:0]       s3_instruction;
    logic [31:0]       s3_data;
    logic              s3_reg_wr;
    logic              s3_mem2r;
    logic              s3_R0_en;
    logic              mem_busy;
    logic              mem_err;

    stage_three #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .halt_sys(halt_sys), .in_memc(in_memc),
        .in_reg_wr(in_reg_wr), .in_R0_en(in_R0_en), .in_instr(in_instr),
        .in_alu(in_alu), .in_R1_data(in_R1_data), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .s3_instruction(s3_instruction), .s3_data(s3_data), .s3_reg_wr(s3_reg_wr),
        .s3_mem2r(s3_mem2r), .s3_R0_en(s3_R0_en), .mem_busy(mem_busy), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        types_pkg::memc_t memc;
        logic [15:0] instr;
        logic [31:0] alu;
        logic [15:0] r1;
        logic        reg_wr;
        logic        r0;
        int          delay;
        logic [15:0] rdata;
        logic        halt;
        logic [31:0] e_data;
        logic        e_mem2r;
        logic        e_reg_wr;
        logic        e_r0;
        logic [15:0] e_instr;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    int op_idx   = 0;

    // Expected write-back state
    logic [15:0] e_instr;
    logic [31:0] e_data;
    logic        e_reg_wr, e_mem2r, e_r0, e_err;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (op %0d): actual %h required %h", name, op_idx, act, exp);
    endtask

    task automatic chk_s3();
        chk("s3_instruction", 32'(s3_instruction), 32'(e_instr));
        chk("s3_data",        s3_data,             e_data);
        chk("s3_reg_wr",      32'(s3_reg_wr),      32'(e_reg_wr));
        chk("s3_mem2r",       32'(s3_mem2r),       32'(e_mem2r));
        chk("s3_R0_en",       32'(s3_R0_en),       32'(e_r0));
        chk("mem_err",        32'(mem_err),        32'(e_err));
    endtask

    task automatic clear_model();
        e_instr = '0; e_data = '0; e_reg_wr = 0; e_mem2r = 0; e_r0 = 0; e_err = 0;
    endtask

    task automatic bubble_model();
        e_instr = '0; e_reg_wr = 0; e_mem2r = 0; e_r0 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input types_pkg::memc_t m, input logic [15:0] ins,
                                input logic [31:0] alu, input logic [15:0] r1,
                                input logic rw, input logic r0, input int dly,
                                input logic [15:0] rd, input logic h,
                                input logic [31:0] ed, input logic em, input logic erw,
                                input logic er0, input logic [15:0] ei);
        vec_t v;
        v.memc = m; v.instr = ins; v.alu = alu; v.r1 = r1; v.reg_wr = rw; v.r0 = r0;
        v.delay = dly; v.rdata = rd; v.halt = h;
        v.e_data = ed; v.e_mem2r = em; v.e_reg_wr = erw; v.e_r0 = er0; v.e_instr = ei;
        return v;
    endfunction

    // One instruction presented in IDLE; model follows the transaction rules.
    task automatic run_op(input vec_t v);
        logic is_mem, store;
        is_mem = v.memc.mem2r | v.memc.memwr;
        store  = v.memc.memwr;
        in_memc = v.memc; in_instr = v.instr; in_alu = v.alu; in_R1_data = v.r1;
        in_reg_wr = v.reg_wr; in_R0_en = v.r0; halt_sys = v.halt;
        if (is_mem && !v.halt) begin
            dm_ack   = (v.delay == 0);
            dm_rdata = (v.delay == 0) ? v.rdata : 16'($urandom);
        end else begin
            dm_ack   = 1'($urandom);
            dm_rdata = 16'($urandom);
        end
        #1;
        if (v.halt || !is_mem) begin
            chk("idle dm_req", 32'(dm_req), 0);
            chk("idle mem_busy", 32'(mem_busy), 0);
            step();
            if (!v.halt) begin
                e_instr = v.instr; e_data = v.alu; e_reg_wr = v.reg_wr;
                e_mem2r = 0; e_r0 = v.r0;
            end
            chk_s3();
        end else begin
            chk("issue dm_req", 32'(dm_req), 1);
            chk("issue dm_addr", 32'(dm_addr), 32'(v.alu[15:0]));
            chk("issue dm_we", 32'(dm_we), 32'(store));
            if (store) chk("issue dm_wdata", 32'(dm_wdata), 32'(v.r1));
            chk("issue mem_busy", 32'(mem_busy), 32'(v.delay != 0));
            for (int k = 1; k <= v.delay; k++) begin
                step();
                bubble_model();
                chk_s3();
                in_memc    = types_pkg::memc_t'(2'($urandom_range(0, 3)));
                in_instr   = 16'($urandom); in_alu = $urandom; in_R1_data = 16'($urandom);
                in_reg_wr  = 1'($urandom); in_R0_en = 1'($urandom);
                halt_sys   = 1'($urandom);
                dm_ack     = (k == v.delay);
                dm_rdata   = (k == v.delay) ? v.rdata : 16'($urandom);
                #1;
                chk("wait dm_req", 32'(dm_req), 1);
                chk("wait dm_addr", 32'(dm_addr), 32'(v.alu[15:0]));
                chk("wait dm_we", 32'(dm_we), 32'(store));
                if (store) chk("wait dm_wdata", 32'(dm_wdata), 32'(v.r1));
                chk("wait mem_busy", 32'(mem_busy), 32'(k != v.delay));
            end
            step();
            e_instr = v.instr; e_data = store ? v.alu : {16'h0, v.rdata};
            e_mem2r = !store; e_reg_wr = 0; e_r0 = 0;
            chk_s3();
        end
        dm_ack = 0;
        op_idx++;
    endtask

    initial begin
        vec_t v;
        int kind;

        tbl[0] = mk(M_NONE, 16'h1234, 32'h0001_0005, 16'h0000, 1, 1, 0, 16'h0000, 0,
                    32'h0001_0005, 0, 1, 1, 16'h1234);
        tbl[1] = mk(M_LD,   16'h4001, 32'h0000_0040, 16'h0000, 1, 1, 0, 16'hBEEF, 0,
                    32'h0000_BEEF, 1, 0, 0, 16'h4001);
        tbl[2] = mk(M_LD,   16'h4002, 32'hFFFF_0040, 16'h0000, 1, 0, 3, 16'h1357, 0,
                    32'h0000_1357, 1, 0, 0, 16'h4002);
        tbl[3] = mk(M_ST,   16'h5003, 32'h1234_0010, 16'hA5A5, 1, 0, 1, 16'h0000, 0,
                    32'h1234_0010, 0, 0, 0, 16'h5003);
        tbl[4] = mk(M_NONE, 16'h6004, 32'hDEAD_BEEF, 16'h0000, 1, 1, 0, 16'h0000, 1,
                    32'h1234_0010, 0, 0, 0, 16'h5003);
        tbl[5] = mk(M_LD,   16'h4005, 32'h0000_0020, 16'h0000, 1, 1, 2, 16'h2222, 1,
                    32'h1234_0010, 0, 0, 0, 16'h5003);
        tbl[6] = mk(M_ST,   16'h5006, 32'h00AB_0077, 16'h0F0F, 1, 1, 0, 16'h0000, 0,
                    32'h00AB_0077, 0, 0, 0, 16'h5006);
        tbl[7] = mk(M_NONE, 16'h7007, 32'hCAFE_F00D, 16'h0000, 0, 0, 0, 16'h0000, 0,
                    32'hCAFE_F00D, 0, 0, 0, 16'h7007);

        rst = 1; halt_sys = 0; in_memc = M_NONE; in_reg_wr = 0; in_R0_en = 0;
        in_instr = '0; in_alu = '0; in_R1_data = '0; dm_ack = 0; dm_rdata = '0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;
        #1;
        chk("rst dm_req", 32'(dm_req), 0);
        chk("rst dm_we", 32'(dm_we), 0);
        chk("rst dm_addr", 32'(dm_addr), 0);
        chk("rst dm_wdata", 32'(dm_wdata), 0);
        chk("rst mem_busy", 32'(mem_busy), 0);
        chk_s3();
        step();

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i]);
            chk("tbl s3_data", s3_data, tbl[i].e_data);
            chk("tbl s3_mem2r", 32'(s3_mem2r), 32'(tbl[i].e_mem2r));
            chk("tbl s3_reg_wr", 32'(s3_reg_wr), 32'(tbl[i].e_reg_wr));
            chk("tbl s3_R0_en", 32'(s3_R0_en), 32'(tbl[i].e_r0));
            chk("tbl s3_instruction", 32'(s3_instruction), 32'(tbl[i].e_instr));
        end

        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 19));
            v = mk(M_NONE, 16'($urandom), $urandom, 16'($urandom), 1'($urandom),
                   1'($urandom), int'($urandom_range(0, 4)), 16'($urandom), 0,
                   '0, 0, 0, 0, '0);
            if (kind >= 17) begin
                v.halt = 1;
                v.memc = types_pkg::memc_t'(2'($urandom_range(0, 3)));
            end else if (kind >= 13) v.memc = M_ST;
            else if (kind >= 8)      v.memc = M_LD;
            run_op(v);
        end

        // Reset two cycles into WAIT drops the access without write-back.
        in_memc = M_LD; in_instr = 16'h4099; in_alu = 32'h0000_0099; in_R1_data = '0;
        halt_sys = 0; dm_ack = 0;
        #1;
        chk("rstw issue dm_req", 32'(dm_req), 1);
        step();
        in_memc = M_NONE;
        #1;
        chk("rstw busy1", 32'(mem_busy), 1);
        step();
        #1;
        chk("rstw busy2", 32'(mem_busy), 1);
        rst = 1;
        #1;
        clear_model();
        chk("rstw dm_req", 32'(dm_req), 0);
        chk("rstw mem_busy", 32'(mem_busy), 0);
        chk_s3();
        halt_sys = 1; dm_ack = 1; dm_rdata = 16'hFFFF;
        @(negedge clk) rst = 0;
        step();
        chk("rstw late ack dm_req", 32'(dm_req), 0);
        chk("rstw late ack busy", 32'(mem_busy), 0);
        chk_s3();
        dm_ack = 0;
        run_op(mk(M_NONE, 16'h1111, 32'h2222_3333, 16'h0, 1, 0, 0, 16'h0, 0,
                  '0, 0, 0, 0, '0));
        chk("rstw pass s3_data", s3_data, 32'h2222_3333);

`ifdef MEM_TIMEOUT_EN
        // No ack: TIMEOUT WAIT cycles, the last of which is the abort cycle.
        in_memc = M_LD; in_instr = 16'h4ABC; in_alu = 32'h0000_0ABC; halt_sys = 0; dm_ack = 0;
        #1;
        chk("to issue busy", 32'(mem_busy), 1);
        for (int w = 1; w <= TB_TIMEOUT; w++) begin
            step();
            bubble_model();
            chk_s3();
            in_memc = M_NONE;
            #1;
            chk("to wait dm_req", 32'(dm_req), 1);
            chk("to wait busy", 32'(mem_busy), 32'(w < TB_TIMEOUT));
        end
        step();
        e_err = 1;
        chk("to dm_req dropped", 32'(dm_req), 0);
        chk("to mem_busy", 32'(mem_busy), 0);
        chk_s3();
        run_op(mk(M_NONE, 16'h7777, 32'h0000_7777, 16'h0, 1, 1, 0, 16'h0, 0,
                  '0, 0, 0, 0, '0));
        chk("to mem_err sticky", 32'(mem_err), 1);
`else
        // Without the timeout a long wait simply persists until ack.
        run_op(mk(M_LD, 16'h4777, 32'h0000_0777, 16'h0, 1, 1, 20, 16'h7777, 0,
                  '0, 0, 0, 0, '0));
        chk("long wait s3_data", s3_data, 32'h0000_7777);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage_three.md
# stage_three

Memory-access / write-back pipeline stage. Consumes the flopped outputs of the ALU stage, performs data-memory loads and stores over a req/ack handshake that tolerates variable memory latency, and drives the `s3_*` write-back and forwarding bus consumed by the register file and hazard unit in stage one. While a memory access is outstanding it asserts `mem_busy`, which upstream stages OR into their stall. When an access is held up, it inserts a write-back bubble.

## Interface
- `TIMEOUT`, default 15: maximum WAIT cycles before an access is aborted. Used only with `MEM_TIMEOUT_EN`.
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `halt_sys`  in  1  system halt from main control
- `in_memc`  in  `types_pkg::memc_t`  fields `.mem2r` (load) and `.memwr` (store)
- `in_reg_wr`  in  1  register write request of the incoming instruction
- `in_R0_en`  in  1  R0 (high-word) write enable of the incoming instruction
- `in_instr`  in  16  incoming instruction
- `in_alu`  in  32  ALU result; `[15:0]` is the memory address for loads/stores
- `in_R1_data`  in  16  store data
- `dm_req`  out  1  memory request
- `dm_we`  out  1  1 = store, 0 = load
- `dm_addr`  out  16  memory address
- `dm_wdata`  out  16  store data
- `dm_ack`  in  1  memory done; `dm_rdata` is valid in the ack cycle
- `dm_rdata`  in  16  load data
- `s3_instruction`  out  16  write-back instruction
- `s3_data`  out  32  write-back / forward data
- `s3_reg_wr`  out  1  register write
- `s3_mem2r`  out  1  load write-back
- `s3_R0_en`  out  1  R0 write
- `mem_busy`  out  1  stall request to upstream stages (combinational)
- `mem_err`  out  1  sticky access-timeout flag

## Operation
- FSM states: IDLE and WAIT.
- The instruction is a memory op when `in_memc.mem2r | in_memc.memwr`.
- **IDLE, non-memory op, no halt:** flop `in_instr`, `in_alu`, `in_reg_wr`, `in_R0_en` to the `s3_*` outputs; `s3_mem2r` = 0.
- **IDLE, memory op, no halt:** drive `dm_req` = 1 for the cycle, with `dm_addr`/`dm_wdata`/`dm_we` taken combinationally from the inputs.
  - `dm_ack` in the same cycle: complete now (zero-wait).
  - Otherwise: latch address, data and we, and the instruction and control bits; go to WAIT.
- **WAIT:** `dm_req` held high and address/data/we driven from the latches; all are stable until ack. On `dm_ack`, complete and return to IDLE.
- **Completion, load:** `s3_data` ← `{16'd0, dm_rdata}`; `s3_mem2r` = 1; `s3_reg_wr` = 0; `s3_R0_en` = 0; `s3_instruction` ← instruction.
- **Completion, store:** `s3_reg_wr`, `s3_mem2r`, `s3_R0_en` = 0; `s3_data` ← `in_alu`; `s3_instruction` ← instruction.
- **`mem_busy`** = (IDLE & memop & !halt_sys & !dm_ack) | (WAIT & !dm_ack).
- **Bubble:** every edge where `mem_busy` is 1 loads `s3_reg_wr` = `s3_mem2r` = `s3_R0_en` = 0 and `s3_instruction` = 0.
- **`halt_sys` in IDLE:** all `s3_*` flops hold, no request is issued, `mem_busy` = 0.
- **`halt_sys` in WAIT:** ignored. The outstanding access completes and its result is captured.
- Never more than one outstanding access.

## Timing
- Reset values: `s3_*` = 0, `dm_req`/`dm_we` = 0, `dm_addr`/`dm_wdata` = 0 (WAIT-latched values), `mem_busy` = 0, `mem_err` = 0, state IDLE.
- Non-memory op: 1-cycle latency to `s3_*`.
- Load or store with ack N cycles after the first req cycle (N ≥ 0):
  - `mem_busy` high for N cycles.
  - `s3_*` carries the result on the edge ending the ack cycle, N+1 cycles after issue.
  - Upstream advances on that same edge.
- `dm_ack` is ignored while `dm_req` = 0.
- Reset during WAIT: immediately IDLE, `dm_req` low, the access is dropped with no write-back.
- WAIT cycle counter: 5 bits, saturating, cleared on entry to WAIT.

## Configuration
- **`MEM_TIMEOUT_EN` defined:**
  - When the WAIT counter reaches `TIMEOUT` without ack, drop `dm_req`, return to IDLE, emit a bubble and set `mem_err` (sticky until `rst`).
  - `mem_busy` falls in the abort cycle.
  - An ack arriving in the abort cycle wins, and the access completes normally.
- **`MEM_TIMEOUT_EN` undefined:** WAIT persists indefinitely, no counter is built, and `mem_err` is tied 0.

## Test plan
- **ALU pass-through:** `in_instr` = 16'h1234, `in_alu` = 32'h0001_0005, `in_reg_wr` = 1, `in_R0_en` = 1 → next edge `s3_data` = 32'h0001_0005, `s3_reg_wr` = 1, `s3_R0_en` = 1; `mem_busy` and `dm_req` stay 0.
- **Zero-wait load:** `mem2r`, `in_alu[15:0]` = 16'h0040, `dm_ack` = 1 with `dm_rdata` = 16'hBEEF in the issue cycle → `dm_addr` = 16'h0040, `mem_busy` = 0; next edge `s3_data` = 32'h0000_BEEF, `s3_mem2r` = 1, `s3_reg_wr` = 0.
- **3-cycle load:** ack 3 cycles after issue with `dm_rdata` = 16'h1357 →
  - `mem_busy` high for 3 cycles;
  - `dm_addr` stable at 16'h0040 throughout, even though inputs change after issue;
  - bubbles (`s3_instruction` = 0, enables 0) during the wait;
  - then `s3_data` = 32'h0000_1357, `s3_mem2r` = 1.
- **Store:** `memwr`, address 16'h0010, `in_R1_data` = 16'hA5A5, ack after 1 cycle → `dm_we` = 1, `dm_wdata` = 16'hA5A5; after completion `s3_reg_wr` = `s3_mem2r` = 0.
- **Timeout:** with `MEM_TIMEOUT_EN`, `TIMEOUT` = 4, no ack → `dm_req` drops after 4 WAIT cycles, `mem_err` = 1 and stays 1, `mem_busy` = 0, bubble written back.
- **Reset mid-WAIT:** assert `rst` 2 cycles into WAIT → `dm_req`, `mem_busy`, all `s3_*` = 0 immediately. A later ack is ignored, and the next non-memory op passes through normally.
